// File: rtl/ifetch_axi.sv
// ifetch_axi -- instruction fetch unit that issues one 64-bit AXI read per
// instruction and selects the 32-bit half addressed by pc[2].
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   pc_i                fetch PC from the fetch stage
//   jump_en_i           redirect; pc_i carries the new target from the next edge
//   hazard_stop_i       downstream stall
//   instr_o             fetched instruction word (held outside VALID)
//   instr_valid_o       instr_o is valid
//   ifetch_en_o         instruction consumed this cycle; fetch stage advances pc
//   fetch_fault_o       delivered word replaced NOP_INSTR due to an error response
//   araddr_o/arvalid_o/arready_i             AXI read-address channel
//   rdata_i/rresp_i/rvalid_i/rready_o        AXI read-data channel
module ifetch_axi #(
   parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] pc,
   input  logic        jump_en,
   input  logic        hazard_stop,
   output logic [31:0] instr,
   output logic        instr_valid,
   output logic        ifetch_en,
   output logic        fetch_fault,
   output logic [63:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [63:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [1:0] {LOAD, ADDR, DATA, VALID} state_e;

   state_e      state_q;
   logic [63:0] araddr_q;
   logic [31:0] instr_q;
   logic        sel_q, kill_q, fault_q, arvalid_q, rready_q, valid_q;

   // Only 8-byte aligned beats are requested; the low PC bits carry no information.
   logic unused_pc;
   assign unused_pc = ^pc[1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= LOAD;
         araddr_q  <= '0;
         instr_q   <= '0;
         sel_q     <= 1'b0;
         kill_q    <= 1'b0;
         fault_q   <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               // Latch every cycle so a redirect seen here is picked up next cycle.
               araddr_q <= {pc[63:3], 3'b000};
               sel_q    <= pc[2];
               kill_q   <= 1'b0;
               if (!jump_en) begin
                  state_q   <= ADDR;
                  arvalid_q <= 1'b1;
               end
            end
            ADDR: begin
               // The request cannot be withdrawn; a redirect only marks it stale.
               if (jump_en) kill_q <= 1'b1;
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= DATA;
               end
            end
            DATA: begin
               if (jump_en) kill_q <= 1'b1;
               if (rvalid) begin
                  rready_q <= 1'b0;
                  if (kill_q || jump_en) begin
                     // Stale response: drop it and refetch from the new pc.
                     kill_q  <= 1'b0;
                     state_q <= LOAD;
                  end else begin
                     valid_q <= 1'b1;
                     state_q <= VALID;
                     fault_q <= (rresp != 2'b00);
                     instr_q <= (rresp != 2'b00) ? NOP_INSTR
                              : (sel_q ? rdata[63:32] : rdata[31:0]);
                  end
               end
            end
            VALID: begin
               // Redirect wins over a stall; otherwise leave once consumed.
               if (jump_en || !hazard_stop) begin
                  valid_q <= 1'b0;
                  fault_q <= 1'b0;
                  kill_q  <= 1'b0;
                  state_q <= LOAD;
               end
            end
         endcase
      end
   end

   assign araddr      = araddr_q;
   assign arvalid     = arvalid_q;
   assign rready      = rready_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign fetch_fault = fault_q;
   assign ifetch_en   = valid_q & ~hazard_stop & ~jump_en;

endmodule

// File: tb/tb_ifetch_axi.sv
// tb_ifetch_axi -- randomized and directed bench for ifetch_axi. A
// transaction-level model (pending request, staleness, delivered word) plus a
// randomized AXI slave predict every output cycle by cycle.
module tb_ifetch_axi;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc;
   logic        jump_en, hazard_stop;
   logic [31:0] instr;
   logic        instr_valid, ifetch_en, fetch_fault;
   logic [63:0] araddr;
   logic        arvalid, arready;
   logic [63:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid, rready;

   ifetch_axi dut (
      .clk(clk), .rst(rst), .pc(pc), .jump_en(jump_en), .hazard_stop(hazard_stop),
      .instr(instr), .instr_valid(instr_valid), .ifetch_en(ifetch_en),
      .fetch_fault(fetch_fault), .araddr(araddr), .arvalid(arvalid),
      .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
      .rready(rready)
   );

   always #5 clk = ~clk;

   int errs = 0, checks = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // reference model state
   logic [63:0] pc_m, pc_prev, req_addr;
   logic [63:0] rsp_data;
   logic [1:0]  rsp_resp;
   logic [31:0] exp_instr;
   bit          req_sel, killed, outst, exp_valid, exp_fault, arv_prev, ar_prev;
   int          rdly, ndeliv;
   // directed overrides: fixed response contents and delay
   bit          fix_en = 0;
   logic [63:0] fix_data;
   logic [1:0]  fix_resp;
   int          fix_dly = -1;

   task automatic model_reset(input logic [63:0] newpc);
      pc_m = newpc; pc_prev = newpc; outst = 0; killed = 0; exp_valid = 0;
      exp_fault = 0; exp_instr = '0; arv_prev = 0; ar_prev = 0; rdly = 0;
   endtask

   task automatic do_reset(input logic [63:0] newpc);
      @(negedge clk);
      rst = 1; jump_en = 0; hazard_stop = 0; arready = 0; rvalid = 0; pc = newpc;
      #1;
      chk("rst_arvalid", arvalid, 0);
      chk("rst_rready", rready, 0);
      chk("rst_valid", instr_valid, 0);
      chk("rst_ifetch", ifetch_en, 0);
      chk("rst_fault", fetch_fault, 0);
      chk("rst_instr", instr, 0);
      chk("rst_araddr", araddr, 0);
      model_reset(newpc);
      @(posedge clk); #1 rst = 0;
   endtask

   // One clock cycle: drive inputs at the falling edge, check outputs, then
   // advance the model to what the next rising edge must produce.
   task automatic cycle(input bit hz, input bit jmp, input logic [63:0] tgt,
                        input bit ar, input bit spur = 0);
      bit exp_ife;
      @(negedge clk);
      pc = pc_m; hazard_stop = hz; jump_en = jmp; arready = ar;
      rvalid = outst ? (rdly == 0) : spur;
      rdata = outst ? rsp_data : 64'({$urandom, $urandom});
      rresp = outst ? rsp_resp : 2'b00;
      #1;
      exp_ife = exp_valid && !hz && !jmp;
      chk("instr_valid", instr_valid, exp_valid);
      chk("ifetch_en", ifetch_en, exp_ife);
      chk("fetch_fault", fetch_fault, exp_valid & exp_fault);
      chk("instr", instr, exp_instr);
      chk("rready", rready, outst);
      if (arv_prev && !ar_prev) chk("arvalid_held", arvalid, 1);
      if (arvalid) begin
         chk("one_outstanding", outst, 0);
         if (!arv_prev) begin
            req_addr = {pc_prev[63:3], 3'b000};
            req_sel  = pc_prev[2];
            killed   = 0;
            chk("araddr_new", araddr, req_addr);
         end else chk("araddr_hold", araddr, req_addr);
      end
      // advance model
      if (jmp && (arvalid || outst)) killed = 1;
      if (outst && rvalid) begin
         if (!killed) begin
            exp_valid = 1;
            exp_fault = (rsp_resp != 0);
            exp_instr = exp_fault ? 32'h00000013
                      : (req_sel ? rsp_data[63:32] : rsp_data[31:0]);
            ndeliv++;
         end
         outst = 0;
      end else if (exp_valid && (exp_ife || jmp)) exp_valid = 0;
      if (outst && !rvalid && rdly > 0) rdly--;
      if (arvalid && ar) begin
         outst = 1;
         rdly  = (fix_dly >= 0) ? fix_dly : $urandom_range(0, 3);
         rsp_data = fix_en ? fix_data : {$urandom, $urandom};
         rsp_resp = fix_en ? fix_resp
                  : (($urandom_range(0, 99) < 15) ? 2'($urandom_range(1, 3)) : 2'b00);
      end
      if (jmp) pc_m = tgt;
      else if (exp_ife) pc_m = pc_m + 64'd4;
      pc_prev = pc; arv_prev = arvalid; ar_prev = ar;
   endtask

   task automatic run_until_valid(input bit hz, input string tag);
      bit seen = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         cycle(hz, 0, 64'd0, 1);
         seen = instr_valid;
      end
      if (!seen) chk(tag, 0, 1);
   endtask

   initial begin
      rst = 1; pc = 0; jump_en = 0; hazard_stop = 0; arready = 0;
      rdata = 0; rresp = 0; rvalid = 0; ndeliv = 0;
      model_reset(0);

      // basic fetch latency, low half
      fix_en = 1; fix_data = 64'h11111111_00000093; fix_resp = 0; fix_dly = 0;
      do_reset(64'h80000000);
      for (int k = 0; k < 4; k++) begin
         cycle(0, 0, 64'd0, 1);
         chk("lat_valid", instr_valid, (k == 3));
         if (k == 1) chk("lat_araddr", araddr, 64'h80000000);
      end
      chk("s1_instr", instr, 32'h00000093);
      chk("s1_ifetch", ifetch_en, 1);
      cycle(0, 0, 64'd0, 0);
      chk("s1_one_cycle", instr_valid, 0);

      // high half
      do_reset(64'h80000004);
      run_until_valid(0, "s2_timeout");
      chk("s2_instr", instr, 32'h11111111);

      // redirect while address is stalled
      do_reset(64'h1000);
      cycle(0, 0, 64'd0, 0);
      for (int k = 0; k < 5; k++) begin
         cycle(0, (k == 2), 64'h2004, 0);
         chk("s3_arvalid", arvalid, 1);
         chk("s3_araddr", araddr, 64'h1000);
      end
      begin
         bit seen = 0;
         for (int i = 0; i < 12 && !seen; i++) begin
            cycle(0, 0, 64'd0, 1);
            seen = arvalid && !arv_prev ? 1'b0 : 1'b0;
            if (arvalid && i > 0 && araddr != 64'h1000) begin
               seen = 1;
               chk("s3_newaddr", araddr, 64'h2000);
            end
            chk("s3_no_valid", instr_valid, 0);
         end
         if (!seen) chk("s3_timeout", 0, 1);
      end
      run_until_valid(0, "s3_fetch_timeout");
      chk("s3_instr", instr, 32'h11111111);

      // stall in VALID
      do_reset(64'h80000000);
      run_until_valid(1, "s4_timeout");
      for (int k = 0; k < 4; k++) begin
         cycle(1, 0, 64'd0, 0);
         chk("s4_stall_valid", instr_valid, 1);
         chk("s4_stall_ife", ifetch_en, 0);
         chk("s4_stall_instr", instr, 32'h00000093);
      end
      cycle(0, 0, 64'd0, 0);
      chk("s4_release_ife", ifetch_en, 1);
      cycle(0, 0, 64'd0, 0);
      chk("s4_load", instr_valid, 0);

      // error response
      fix_resp = 2'b10;
      do_reset(64'h80000000);
      run_until_valid(0, "s5_timeout");
      chk("s5_instr", instr, 32'h00000013);
      chk("s5_fault", fetch_fault, 1);
      fix_resp = 2'b00;

      // reset during DATA, stray response afterwards
      fix_dly = 4;
      do_reset(64'h3000);
      cycle(0, 0, 64'd0, 1);
      cycle(0, 0, 64'd0, 1);
      cycle(0, 0, 64'd0, 0);
      chk("s6_in_data", rready, 1);
      do_reset(64'h3008);
      for (int k = 0; k < 3; k++) begin
         cycle(0, 0, 64'd0, 0, 1);
         chk("s6_rready", rready, 0);
         chk("s6_valid", instr_valid, 0);
      end
      fix_dly = 1;
      run_until_valid(0, "s6_timeout");
      chk("s6_instr", instr, 32'h00000093);

      // randomized traffic
      fix_en = 0; fix_dly = -1; ndeliv = 0;
      do_reset(64'h80000000);
      for (int i = 0; i < 4000; i++) begin
         bit j = ($urandom_range(0, 99) < 8);
         cycle(($urandom_range(0, 99) < 30), j,
               {32'h0, $urandom} & 64'hFFFF_FFFC,
               ($urandom_range(0, 99) < 60));
      end
      chk("progress", (ndeliv >= 100), 1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
